fetch_unit: RTL

- Instruction-fetch front end of the single-cycle/extended RISC-V core.
- Owns the program counter and drives the byte address into the combinational instruction memory. That memory returns `imem_rdata` in the same cycle.
- Buffers fetched {pc, instruction} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute; a redirect flushes all buffered entries.

---
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_unit.sv | 92 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory, redirect and decode-side signals of the fetch unit
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign_err;

  // Fetch unit side
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output misalign_err
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter plus small {pc, instr} fetch buffer with redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [31:0]   buf_pc_q    [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];

  logic valid;
  logic pop;
  logic push;

  // A redirect squashes the head, so it also suppresses the pop.
  assign valid = (count_q != '0);
  assign pop   = valid & bus.out_ready & ~bus.redirect_valid;
  assign push  = ~bus.redirect_valid & ((count_q < CW'(DEPTH)) | (valid & bus.out_ready));

  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = valid;
  assign bus.out_pc       = valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
  assign bus.out_instr    = valid ? buf_instr_q[rd_ptr_q] : 32'h0;
  assign bus.out_pc_plus4 = valid ? (buf_pc_q[rd_ptr_q] + 32'd4) : 32'h0;
  assign bus.misalign_err = err_q;

  // Next-state for pc, pointers, occupancy and the sticky misalign flag
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        err_d = 1'b1;
      end
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Buffer storage; contents are only visible while counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= pc_q;
      buf_instr_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end
endmodule
